// File: rtl/mem_access_stage.sv
// mem_access_stage
// Pipelined-CPU MEM stage backed by a multi-cycle data RAM. It accepts one
// load or store request in IDLE. It holds the pipeline with Stall for LAT
// cycles, and commits the access on the edge that ends the last wait cycle.
// It then spends one DONE cycle so that the pipeline can advance.
// Misaligned requests, and requests asserting load and store together, do not
// touch the RAM. They raise a one-cycle Mem_Err pulse instead.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset (RAM contents are kept)
//   Mem_Rd       load request from EX/MEM
//   Mem_Wr       store request from EX/MEM
//   Size[1:0]    00 byte, 01 halfword, 10/11 word
//   Ld_Unsigned  zero-extend (1) or sign-extend (0) sub-word loads
//   Addr[31:0]   byte address; only Addr[ADDR_W+1:0] is decoded
//   Wr_Data      store data, taken from the low lanes
//   Read_New     registered load result toward MEM/WB
//   Stall        freezes the front of the pipeline while an access is in flight
//   Mem_Err      one-cycle pulse for a misaligned or conflicting request
module mem_access_stage #(
  parameter int ADDR_W = 8,
  parameter int LAT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Mem_Rd,
  input  logic        Mem_Wr,
  input  logic [1:0]  Size,
  input  logic        Ld_Unsigned,
  input  logic [31:0] Addr,
  input  logic [31:0] Wr_Data,
  output logic [31:0] Read_New,
  output logic        Stall,
  output logic        Mem_Err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state, w_nextState;
  logic [2:0]        r_cnt, w_nextCnt;
  logic              w_commit, w_latch;

  logic              r_isWr;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wrData;
  logic              r_err;
  logic [31:0]       r_readNew;
  logic [31:0]       r_mem [2**ADDR_W];

  logic              w_req, w_aligned, w_accept, w_err;
  logic              w_cIsWr, w_cUnsigned;
  logic [1:0]        w_cSize;
  logic [ADDR_W+1:0] w_cAddr;
  logic [31:0]       w_cWrData;
  logic [ADDR_W-1:0] w_idx;
  logic [31:0]       w_oldWord, w_newWord, w_loadVal;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic              w_unusedAddr;

  // A request is exactly one of load/store. Its alignment decides whether the
  // request is accepted or rejected with an error. Both decisions only apply
  // in IDLE.
  always_comb begin
    w_req = Mem_Rd ^ Mem_Wr;
    case (Size)
      2'b00:   w_aligned = 1'b1;
      2'b01:   w_aligned = ~Addr[0];
      default: w_aligned = (Addr[1:0] == 2'b00);
    endcase
    w_accept = (r_state == S_IDLE) && w_req && w_aligned;
    w_err    = (r_state == S_IDLE) && ((Mem_Rd && Mem_Wr) || (w_req && !w_aligned));
  end

  // Address bits above the decoded range are ignored, so addresses wrap.
  assign w_unusedAddr = ^Addr[31:ADDR_W+2];

  // Next-state logic. With LAT=1 the commit happens on the edge that ends the
  // accepting IDLE cycle. In that case there are no BUSY cycles, and the commit
  // uses the live inputs instead of the captured copy.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_commit    = 1'b0;
    w_latch     = 1'b0;
    Stall       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          Stall   = 1'b1;
          w_latch = 1'b1;
          if (LAT == 1) begin
            w_commit    = 1'b1;
            w_nextState = S_DONE;
            w_nextCnt   = 3'd0;
          end else begin
            w_nextState = S_BUSY;
            w_nextCnt   = 3'(LAT - 1);
          end
        end
      end
      S_BUSY: begin
        Stall = 1'b1;
        if (r_cnt <= 3'd1) begin
          w_commit    = 1'b1;
          w_nextState = S_DONE;
          w_nextCnt   = 3'd0;
        end else begin
          w_nextCnt = r_cnt - 3'd1;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
    if (rst) begin
      Stall = 1'b0;
    end
  end

  // State, counter and error pulse. Reset wins over any pending commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      r_err   <= w_err;
    end
  end

  // The request is captured when it is accepted, so that input changes while
  // BUSY or DONE cannot disturb the access in flight.
  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_isWr     <= Mem_Wr;
      r_size     <= Size;
      r_unsigned <= Ld_Unsigned;
      r_addr     <= Addr[ADDR_W+1:0];
      r_wrData   <= Wr_Data;
    end
  end

  // Select the request that commits: the live inputs only in the LAT=1 case,
  // where the commit happens in IDLE.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_cIsWr     = Mem_Wr;
      w_cSize     = Size;
      w_cUnsigned = Ld_Unsigned;
      w_cAddr     = Addr[ADDR_W+1:0];
      w_cWrData   = Wr_Data;
    end else begin
      w_cIsWr     = r_isWr;
      w_cSize     = r_size;
      w_cUnsigned = r_unsigned;
      w_cAddr     = r_addr;
      w_cWrData   = r_wrData;
    end
    w_idx     = w_cAddr[ADDR_W+1:2];
    w_oldWord = r_mem[w_idx];
  end

  // Little-endian lane merge for stores and lane extraction for loads.
  // Unselected lanes keep their old contents.
  always_comb begin
    w_newWord = w_oldWord;
    case (w_cAddr[1:0])
      2'b00:   w_byte = w_oldWord[7:0];
      2'b01:   w_byte = w_oldWord[15:8];
      2'b10:   w_byte = w_oldWord[23:16];
      default: w_byte = w_oldWord[31:24];
    endcase
    w_half = w_cAddr[1] ? w_oldWord[31:16] : w_oldWord[15:0];
    case (w_cSize)
      2'b00: begin
        case (w_cAddr[1:0])
          2'b00:   w_newWord[7:0]   = w_cWrData[7:0];
          2'b01:   w_newWord[15:8]  = w_cWrData[7:0];
          2'b10:   w_newWord[23:16] = w_cWrData[7:0];
          default: w_newWord[31:24] = w_cWrData[7:0];
        endcase
        w_loadVal = w_cUnsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      2'b01: begin
        if (w_cAddr[1]) begin
          w_newWord[31:16] = w_cWrData[15:0];
        end else begin
          w_newWord[15:0] = w_cWrData[15:0];
        end
        w_loadVal = w_cUnsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      end
      default: begin
        w_newWord = w_cWrData;
        w_loadVal = w_oldWord;
      end
    endcase
  end

  // RAM write on a store commit. The RAM is never cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && w_commit && w_cIsWr) begin
      r_mem[w_idx] <= w_newWord;
    end
  end

  // The load result only changes when a load commits or on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_readNew <= 32'd0;
    end else if (w_commit && !w_cIsWr) begin
      r_readNew <= w_loadVal;
    end
  end

  assign Read_New = r_readNew;
  assign Mem_Err  = r_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage
// Directed and random loads and stores against a word-array reference model
// of the data RAM. Expected Stall, Mem_Err and Read_New timing is derived from
// the access rules: LAT stalled cycles, then one DONE cycle.
module tb_mem_access_stage;

  localparam int ADDR_W = 8;
  localparam int LAT    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        Mem_Rd, Mem_Wr, Ld_Unsigned;
  logic [1:0]  Size;
  logic [31:0] Addr, Wr_Data;
  logic [31:0] Read_New;
  logic        Stall, Mem_Err;

  int          testCount = 0;
  int          failCount = 0;
  logic [31:0] modelMem [256];
  logic [31:0] modelRead;
  logic        expErr;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(ADDR_W), .LAT(LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .Mem_Rd      (Mem_Rd),
    .Mem_Wr      (Mem_Wr),
    .Size        (Size),
    .Ld_Unsigned (Ld_Unsigned),
    .Addr        (Addr),
    .Wr_Data     (Wr_Data),
    .Read_New    (Read_New),
    .Stall       (Stall),
    .Mem_Err     (Mem_Err)
  );

  // One comparison: count it, and report it if it fails.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic isMisaligned(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b00) return 1'b0;
    if (sz == 2'b01) return a[0];
    return (a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] modelLoad(input logic [1:0] sz, input logic uns, input logic [31:0] a);
    logic [31:0] word, v;
    int sh;
    word = modelMem[a[9:2]];
    if (sz == 2'b00) begin
      sh = 8 * a[1:0];
      v = (word >> sh) & 32'hFF;
      if (!uns && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 2'b01) begin
      sh = 16 * a[1];
      v = (word >> sh) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = word;
    end
    return v;
  endfunction

  task automatic modelStore(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] mask, wd;
    int sh;
    if (sz == 2'b00) begin
      sh = 8 * a[1:0];
      mask = 32'hFF << sh;
      wd = (d & 32'hFF) << sh;
    end else if (sz == 2'b01) begin
      sh = 16 * a[1];
      mask = 32'hFFFF << sh;
      wd = (d & 32'hFFFF) << sh;
    end else begin
      mask = 32'hFFFF_FFFF;
      wd = d;
    end
    modelMem[a[9:2]] = (modelMem[a[9:2]] & ~mask) | (wd & mask);
  endtask

  // Drive one request in the next cycle and follow it until it completes.
  // Error and empty requests take one cycle; accepted ones stall LAT cycles and
  // end in the DONE cycle with the request still held.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] sz,
                               input logic uns, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    Mem_Rd = rd; Mem_Wr = wr; Size = sz; Ld_Unsigned = uns; Addr = a; Wr_Data = d;
    #1;
    checkOutput("memErrStart", {31'd0, Mem_Err}, {31'd0, expErr});
    checkOutput("readNewHold", Read_New, modelRead);
    if ((rd && wr) || ((rd ^ wr) && isMisaligned(sz, a))) begin
      checkOutput("stallOnErr", {31'd0, Stall}, 32'd0);
      expErr = 1'b1;
    end else if (!(rd ^ wr)) begin
      checkOutput("stallIdle", {31'd0, Stall}, 32'd0);
      expErr = 1'b0;
    end else begin
      checkOutput("stallAccept", {31'd0, Stall}, 32'd1);
      expErr = 1'b0;
      for (int k = 1; k < LAT; k++) begin
        @(negedge clk); #1;
        checkOutput("stallBusy", {31'd0, Stall}, 32'd1);
        checkOutput("memErrBusy", {31'd0, Mem_Err}, 32'd0);
      end
      @(negedge clk); #1;
      if (wr) modelStore(sz, a, d);
      else modelRead = modelLoad(sz, uns, a);
      checkOutput("stallDone", {31'd0, Stall}, 32'd0);
      checkOutput("readNewDone", Read_New, modelRead);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) modelMem[i] = 32'd0;
    rst = 1'b1; Mem_Rd = 1'b0; Mem_Wr = 1'b0; Size = 2'b00; Ld_Unsigned = 1'b0;
    Addr = 32'd0; Wr_Data = 32'd0;
    modelRead = 32'd0; expErr = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("stallInReset", {31'd0, Stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("resetReadNew", Read_New, 32'd0);
    checkOutput("resetMemErr", {31'd0, Mem_Err}, 32'd0);
    checkOutput("resetStall", {31'd0, Stall}, 32'd0);

    // Fill the word region used below with known values.
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, i * 4, $urandom);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);

    // Word store then word load.
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    checkOutput("wordLoadConst", Read_New, 32'hDEAD_BEEF);

    // Byte store with signed and unsigned byte loads, then word load.
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'd0);
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 32'h12, 32'h80);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h12, 32'd0);
    checkOutput("byteSigned", Read_New, 32'hFFFF_FF80);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 32'h12, 32'd0);
    checkOutput("byteUnsigned", Read_New, 32'h0000_0080);
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    checkOutput("wordAfterByte", Read_New, 32'h0080_0000);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);

    // Misaligned halfword load, then an aligned request in the very next cycle.
    applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 32'h11, 32'd0);
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0);

    // Conflicting request, then the word is read back unchanged.
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h1111_2222);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0);

    // Reset on the commit edge of a store aborts it.
    @(negedge clk);
    Mem_Rd = 1'b0; Mem_Wr = 1'b1; Size = 2'b10; Addr = 32'h30; Wr_Data = 32'h1234_5678;
    #1;
    checkOutput("abortAccept", {31'd0, Stall}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abortStallInReset", {31'd0, Stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0; Mem_Wr = 1'b0;
    #1;
    checkOutput("abortStallAfter", {31'd0, Stall}, 32'd0);
    checkOutput("abortReadNew", Read_New, 32'd0);
    modelRead = 32'd0;
    expErr = 1'b0;
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'd0);

    // Address wrap: 0x400 aliases word 0.
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h400, 32'hA5A5_A5A5);
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h000, 32'd0);
    checkOutput("wrapConst", Read_New, 32'hA5A5_A5A5);

    // Random mix within the first 16 words, with random upper address bits.
    for (int n = 0; n < 120; n++) begin
      logic [2:0]  kind;
      logic        rd, wr;
      logic [31:0] a;
      kind = 3'($urandom_range(0, 7));
      rd = (kind == 3'd0) || (kind >= 3'd2 && kind <= 3'd4);
      wr = (kind == 3'd0) || (kind >= 3'd5);
      a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
      applyStimulus(rd, wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom);
    end
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
